// File: rtl/decode_stage_pl.sv
// Decode stage: register file with write-through bypass, RV32I-subset decoder, immediate
// generator and ID/EX register. Defining LOAD_USE_HAZARD_EN adds load-use detection (LoadUseStallD).
module decode_stage_pl #(
   parameter  int XLEN     = 32,
   parameter  int NUM_REGS = 32,
   localparam int RA_W     = $clog2(NUM_REGS)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ValidD,
   input  logic [31:0]     InstrD,
   input  logic [XLEN-1:0] PCD,
   input  logic [XLEN-1:0] PCPlus4D,
   input  logic            StallD,
   input  logic            FlushE,
   input  logic            RegWriteW,
   input  logic [RA_W-1:0] RDW,
   input  logic [XLEN-1:0] ResultW,
`ifdef LOAD_USE_HAZARD_EN
   output logic            LoadUseStallD,
`endif
   output logic            ValidE,
   output logic            RegWriteE,
   output logic            ALUSrcE,
   output logic            MemWriteE,
   output logic            BranchE,
   output logic            JumpE,
   output logic            IllegalE,
   output logic [1:0]      ResultSrcE,
   output logic [2:0]      ALUControlE,
   output logic [XLEN-1:0] RD1_E,
   output logic [XLEN-1:0] RD2_E,
   output logic [XLEN-1:0] Imm_Ext_E,
   output logic [XLEN-1:0] PCE,
   output logic [XLEN-1:0] PCPlus4E,
   output logic [RA_W-1:0] RS1_E,
   output logic [RA_W-1:0] RS2_E,
   output logic [RA_W-1:0] RD_E
);

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_IALU = 7'b0010011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   typedef struct packed {
      logic            valid;
      logic            regwrite;
      logic            alusrc;
      logic            memwrite;
      logic            branch;
      logic            jump;
      logic            illegal;
      logic [1:0]      resultsrc;
      logic [2:0]      aluctl;
      logic [XLEN-1:0] rd1;
      logic [XLEN-1:0] rd2;
      logic [XLEN-1:0] imm;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc4;
      logic [RA_W-1:0] rs1;
      logic [RA_W-1:0] rs2;
      logic [RA_W-1:0] rd;
   } idex_t;

   // Instruction register fields are 5 bits; keep the low RA_W bits (zero-extend if wider).
   function automatic logic [RA_W-1:0] reg_idx(input logic [4:0] field);
      logic [RA_W+4:0] ext;
      ext = {{RA_W{1'b0}}, field};
      return ext[RA_W-1:0];
   endfunction

   logic [XLEN-1:0] r_rf [NUM_REGS];
   idex_t           r_idex;
   idex_t           w_dec;
   logic [RA_W-1:0] w_rs1, w_rs2, w_rd;
   logic [XLEN-1:0] w_rd1, w_rd2;
   logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_j;
   logic [6:0]      w_opcode;
   logic [2:0]      w_funct3;
   logic [6:0]      w_funct7;
   logic            w_bubble;

   assign w_opcode = InstrD[6:0];
   assign w_funct3 = InstrD[14:12];
   assign w_funct7 = InstrD[31:25];
   assign w_rs1    = reg_idx(InstrD[19:15]);
   assign w_rs2    = reg_idx(InstrD[24:20]);
   assign w_rd     = reg_idx(InstrD[11:7]);

   assign w_imm_i = XLEN'($signed(InstrD[31:20]));
   assign w_imm_s = XLEN'($signed({InstrD[31:25], InstrD[11:7]}));
   assign w_imm_b = XLEN'($signed({InstrD[31], InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0}));
   assign w_imm_j = XLEN'($signed({InstrD[31], InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0}));

   // Register file: x0 is never written; reads of x0 are forced to zero below.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) r_rf[i] <= '0;
      end else if (RegWriteW && (RDW != '0)) begin
         r_rf[RDW] <= ResultW;
      end
   end

   // Read port 1 with write-through bypass
   always_comb begin
      if (w_rs1 == '0)                          w_rd1 = '0;
      else if (RegWriteW && (RDW == w_rs1))     w_rd1 = ResultW;
      else                                      w_rd1 = r_rf[w_rs1];
   end

   // Read port 2 with write-through bypass
   always_comb begin
      if (w_rs2 == '0)                          w_rd2 = '0;
      else if (RegWriteW && (RDW == w_rs2))     w_rd2 = ResultW;
      else                                      w_rd2 = r_rf[w_rs2];
   end

   // Main/ALU decode; an unsupported encoding leaves every control at zero and flags illegal
   always_comb begin
      w_dec       = '0;
      w_dec.valid = 1'b1;
      w_dec.rd1   = w_rd1;
      w_dec.rd2   = w_rd2;
      w_dec.pc    = PCD;
      w_dec.pc4   = PCPlus4D;
      w_dec.rs1   = w_rs1;
      w_dec.rs2   = w_rs2;
      w_dec.rd    = w_rd;
      case (w_opcode)
         OP_LW: begin
            if (w_funct3 == 3'b010) begin
               w_dec.regwrite  = 1'b1;
               w_dec.alusrc    = 1'b1;
               w_dec.resultsrc = 2'b01;
               w_dec.imm       = w_imm_i;
            end else begin
               w_dec.illegal   = 1'b1;
            end
         end
         OP_SW: begin
            if (w_funct3 == 3'b010) begin
               w_dec.memwrite  = 1'b1;
               w_dec.alusrc    = 1'b1;
               w_dec.imm       = w_imm_s;
            end else begin
               w_dec.illegal   = 1'b1;
            end
         end
         OP_R: begin
            w_dec.regwrite = 1'b1;
            case ({w_funct7, w_funct3})
               {7'b0000000, 3'b000}: w_dec.aluctl = ALU_ADD;
               {7'b0100000, 3'b000}: w_dec.aluctl = ALU_SUB;
               {7'b0000000, 3'b111}: w_dec.aluctl = ALU_AND;
               {7'b0000000, 3'b110}: w_dec.aluctl = ALU_OR;
               {7'b0000000, 3'b010}: w_dec.aluctl = ALU_SLT;
               default: begin
                  w_dec.regwrite = 1'b0;
                  w_dec.illegal  = 1'b1;
               end
            endcase
         end
         OP_IALU: begin
            case (w_funct3)
               3'b000:  w_dec.aluctl  = ALU_ADD;
               3'b010:  w_dec.aluctl  = ALU_SLT;
               3'b110:  w_dec.aluctl  = ALU_OR;
               3'b111:  w_dec.aluctl  = ALU_AND;
               default: w_dec.illegal = 1'b1;
            endcase
            if (!w_dec.illegal) begin
               w_dec.regwrite = 1'b1;
               w_dec.alusrc   = 1'b1;
               w_dec.imm      = w_imm_i;
            end else begin
               w_dec.imm      = '0;
            end
         end
         OP_BEQ: begin
            if (w_funct3 == 3'b000) begin
               w_dec.branch = 1'b1;
               w_dec.aluctl = ALU_SUB;
               w_dec.imm    = w_imm_b;
            end else begin
               w_dec.illegal = 1'b1;
            end
         end
         OP_JAL: begin
            w_dec.regwrite  = 1'b1;
            w_dec.jump      = 1'b1;
            w_dec.resultsrc = 2'b10;
            w_dec.imm       = w_imm_j;
         end
         default: w_dec.illegal = 1'b1;
      endcase
   end

`ifdef LOAD_USE_HAZARD_EN
   logic w_load_use;
   assign w_load_use = r_idex.valid && (r_idex.resultsrc == 2'b01) && (r_idex.rd != '0) &&
                       ((r_idex.rd == w_rs1) || (r_idex.rd == w_rs2)) && ValidD;
   assign LoadUseStallD = w_load_use;
   assign w_bubble      = !ValidD || w_load_use;
`else
   assign w_bubble      = !ValidD;
`endif

   // ID/EX register: flush beats stall, stall beats bubble/load
   always_ff @(posedge clk or posedge rst) begin
      if (rst)           r_idex <= '0;
      else if (FlushE)   r_idex <= '0;
      else if (StallD)   r_idex <= r_idex;
      else if (w_bubble) r_idex <= '0;
      else               r_idex <= w_dec;
   end

   assign ValidE      = r_idex.valid;
   assign RegWriteE   = r_idex.regwrite;
   assign ALUSrcE     = r_idex.alusrc;
   assign MemWriteE   = r_idex.memwrite;
   assign BranchE     = r_idex.branch;
   assign JumpE       = r_idex.jump;
   assign IllegalE    = r_idex.illegal;
   assign ResultSrcE  = r_idex.resultsrc;
   assign ALUControlE = r_idex.aluctl;
   assign RD1_E       = r_idex.rd1;
   assign RD2_E       = r_idex.rd2;
   assign Imm_Ext_E   = r_idex.imm;
   assign PCE         = r_idex.pc;
   assign PCPlus4E    = r_idex.pc4;
   assign RS1_E       = r_idex.rs1;
   assign RS2_E       = r_idex.rs2;
   assign RD_E        = r_idex.rd;

endmodule

// File: tb/tb_decode_stage_pl.sv
// Self-checking bench for decode_stage_pl: directed vector table, hand-written multi-cycle
// sequences and randomized traffic against a behavioural model of the decode stage.
module tb_decode_stage_pl;

   logic        clk = 1'b0;
   logic        rst;
   logic        ValidD;
   logic [31:0] InstrD, PCD, PCPlus4D;
   logic        StallD, FlushE, RegWriteW;
   logic [4:0]  RDW;
   logic [31:0] ResultW;
   logic        ValidE, RegWriteE, ALUSrcE, MemWriteE, BranchE, JumpE, IllegalE;
   logic [1:0]  ResultSrcE;
   logic [2:0]  ALUControlE;
   logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E;
   logic [4:0]  RS1_E, RS2_E, RD_E;
`ifdef LOAD_USE_HAZARD_EN
   logic        LoadUseStallD;
`endif

   decode_stage_pl #(.XLEN(32), .NUM_REGS(32)) dut (
      .clk(clk), .rst(rst), .ValidD(ValidD), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
      .StallD(StallD), .FlushE(FlushE), .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW),
`ifdef LOAD_USE_HAZARD_EN
      .LoadUseStallD(LoadUseStallD),
`endif
      .ValidE(ValidE), .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
      .BranchE(BranchE), .JumpE(JumpE), .IllegalE(IllegalE), .ResultSrcE(ResultSrcE),
      .ALUControlE(ALUControlE), .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E),
      .PCE(PCE), .PCPlus4E(PCPlus4E), .RS1_E(RS1_E), .RS2_E(RS2_E), .RD_E(RD_E)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        valid, regwrite, alusrc, memwrite, branch, jump, illegal;
      logic [1:0]  resultsrc;
      logic [2:0]  aluctl;
      logic [31:0] rd1, rd2, imm, pc, pc4;
      logic [4:0]  rs1, rs2, rd;
   } exp_t;

   typedef struct {
      logic [31:0] instr;
      logic        validd;
      logic [11:0] ctrl;
      logic [31:0] imm;
   } vec_t;

   int          n_pass  = 0;
   int          n_total = 0;
   exp_t        m_e;
   logic [31:0] m_rf [32];
   vec_t        vecs [13];

   task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   function automatic logic [11:0] act_ctrl();
      return {ValidE, RegWriteE, ALUSrcE, MemWriteE, BranchE, JumpE, IllegalE, ResultSrcE, ALUControlE};
   endfunction

   function automatic logic [174:0] act_data();
      return {RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, RS1_E, RS2_E, RD_E};
   endfunction

   function automatic logic [11:0] exp_ctrl(input exp_t e);
      return {e.valid, e.regwrite, e.alusrc, e.memwrite, e.branch, e.jump, e.illegal, e.resultsrc, e.aluctl};
   endfunction

   function automatic logic [174:0] exp_data(input exp_t e);
      return {e.rd1, e.rd2, e.imm, e.pc, e.pc4, e.rs1, e.rs2, e.rd};
   endfunction

   // ALU operation for an R/I funct3; add/sub distinction handled by the caller.
   function automatic logic alu_of_f3(input logic [2:0] f3, output logic [2:0] ctl);
      ctl = 3'd0;
      case (f3)
         3'd0: begin ctl = 3'd0; return 1'b1; end
         3'd2: begin ctl = 3'd5; return 1'b1; end
         3'd6: begin ctl = 3'd3; return 1'b1; end
         3'd7: begin ctl = 3'd2; return 1'b1; end
         default: return 1'b0;
      endcase
   endfunction

   function automatic exp_t decode_ref(input logic [31:0] ins);
      exp_t       e;
      logic [6:0] op;
      logic [2:0] f3, ctl;
      logic [6:0] f7;
      logic       ok;
      e = '0; op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
      e.valid = 1'b1;
      ok = 1'b0;
      if (op == 7'h03 && f3 == 3'd2) begin
         ok = 1'b1; e.regwrite = 1'b1; e.alusrc = 1'b1; e.resultsrc = 2'b01;
         e.imm = 32'($signed(ins[31:20]));
      end else if (op == 7'h23 && f3 == 3'd2) begin
         ok = 1'b1; e.memwrite = 1'b1; e.alusrc = 1'b1;
         e.imm = 32'($signed({ins[31:25], ins[11:7]}));
      end else if (op == 7'h33) begin
         if (f7 == 7'h20) begin ok = (f3 == 3'd0); ctl = 3'd1; end
         else if (f7 == 7'h00) ok = alu_of_f3(f3, ctl);
         else ok = 1'b0;
         if (ok) begin e.regwrite = 1'b1; e.aluctl = ctl; end
      end else if (op == 7'h13) begin
         ok = alu_of_f3(f3, ctl);
         if (ok) begin
            e.regwrite = 1'b1; e.alusrc = 1'b1; e.aluctl = ctl;
            e.imm = 32'($signed(ins[31:20]));
         end
      end else if (op == 7'h63 && f3 == 3'd0) begin
         ok = 1'b1; e.branch = 1'b1; e.aluctl = 3'd1;
         e.imm = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
      end else if (op == 7'h6F) begin
         ok = 1'b1; e.regwrite = 1'b1; e.jump = 1'b1; e.resultsrc = 2'b10;
         e.imm = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
      end
      e.illegal = !ok;
      return e;
   endfunction

   function automatic logic [31:0] rf_read(input logic [4:0] rs);
      if (rs == 5'd0) return 32'd0;
      if (RegWriteW && RDW == rs) return ResultW;
      return m_rf[rs];
   endfunction

   function automatic logic model_load_use();
      logic [4:0] rs1, rs2;
      rs1 = InstrD[19:15];
      rs2 = InstrD[24:20];
`ifdef LOAD_USE_HAZARD_EN
      return m_e.valid && m_e.resultsrc == 2'b01 && m_e.rd != 5'd0 &&
             (m_e.rd == rs1 || m_e.rd == rs2) && ValidD;
`else
      return 1'b0;
`endif
   endfunction

   // One clock: predict, advance, compare the whole ID/EX image against the model.
   task automatic tick(input string name);
      exp_t nxt;
      logic lus;
      lus = model_load_use();
`ifdef LOAD_USE_HAZARD_EN
      check({name, "_lus"}, {191'd0, LoadUseStallD}, {191'd0, lus});
`endif
      nxt     = decode_ref(InstrD);
      nxt.rs1 = InstrD[19:15];
      nxt.rs2 = InstrD[24:20];
      nxt.rd  = InstrD[11:7];
      nxt.rd1 = rf_read(nxt.rs1);
      nxt.rd2 = rf_read(nxt.rs2);
      nxt.pc  = PCD;
      nxt.pc4 = PCPlus4D;
      if (FlushE) m_e = '0;
      else if (!StallD) m_e = (!ValidD || lus) ? exp_t'('0) : nxt;
      @(posedge clk);
      if (RegWriteW && RDW != 5'd0) m_rf[RDW] = ResultW;
      #1;
      check({name, "_ctrl"}, {180'd0, act_ctrl()}, {180'd0, exp_ctrl(m_e)});
      check({name, "_data"}, {17'd0, act_data()}, {17'd0, exp_data(m_e)});
   endtask

   task automatic model_reset();
      m_e = '0;
      for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
   endtask

   task automatic drive(input logic [31:0] ins, input logic v, input logic st, input logic fl);
      InstrD = ins; ValidD = v; StallD = st; FlushE = fl;
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] r, ins;
      r = $urandom();
      case ($urandom_range(0, 7))
         0:       ins = {r[31:15], 3'b010, r[11:7], 7'b0000011};
         1:       ins = {r[31:15], 3'b010, r[11:7], 7'b0100011};
         2:       ins = {7'b0000000, r[24:15], r[14:12], r[11:7], 7'b0110011};
         3:       ins = {7'b0100000, r[24:15], r[14:12], r[11:7], 7'b0110011};
         4:       ins = {r[31:7], 7'b0010011};
         5:       ins = {r[31:15], 3'b000, r[11:7], 7'b1100011};
         6:       ins = {r[31:7], 7'b1101111};
         default: ins = r;
      endcase
      if ($urandom_range(0, 1) == 1) begin
         ins[24:20] = 5'($urandom_range(0, 3));
         ins[19:15] = 5'($urandom_range(0, 3));
         ins[11:7]  = 5'($urandom_range(0, 3));
      end
      return ins;
   endfunction

   initial begin
      vecs[0]  = '{32'h00F00793, 1'b1, 12'hE00, 32'h0000000F};
      vecs[1]  = '{32'hFE000CE3, 1'b1, 12'h881, 32'hFFFFFFF8};
      vecs[2]  = '{32'hFFFFFFFF, 1'b1, 12'h820, 32'h00000000};
      vecs[3]  = '{32'h0000A283, 1'b1, 12'hE08, 32'h00000000};
      vecs[4]  = '{32'h000081B3, 1'b1, 12'hC00, 32'h00000000};
      vecs[5]  = '{32'hFE20AE23, 1'b1, 12'hB00, 32'hFFFFFFFC};
      vecs[6]  = '{32'h008000EF, 1'b1, 12'hC50, 32'h00000008};
      vecs[7]  = '{32'h407302B3, 1'b1, 12'hC01, 32'h00000000};
      vecs[8]  = '{32'hFFF12213, 1'b1, 12'hE05, 32'hFFFFFFFF};
      vecs[9]  = '{32'h003160B3, 1'b1, 12'hC03, 32'h00000000};
      vecs[10] = '{32'h003140B3, 1'b1, 12'h820, 32'h00000000};
      vecs[11] = '{32'h80017093, 1'b1, 12'hE02, 32'hFFFFF800};
      vecs[12] = '{32'h00F00793, 1'b0, 12'h000, 32'h00000000};

      rst = 1'b1; RegWriteW = 1'b0; RDW = 5'd0; ResultW = 32'd0;
      PCD = 32'h100; PCPlus4D = 32'h104;
      drive(32'h00F00793, 1'b1, 1'b0, 1'b0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("reset_ctrl", {180'd0, act_ctrl()}, 192'd0);
      check("reset_data", {17'd0, act_data()}, 192'd0);
      @(negedge clk);
      rst = 1'b0;

      // Test-plan addi: explicit field checks
      tick("addi");
      check("addi_rd", {187'd0, RD_E}, 192'd15);
      check("addi_rs1", {187'd0, RS1_E}, 192'd0);
      check("addi_imm", {160'd0, Imm_Ext_E}, {160'd0, 32'h0000000F});

      // Directed decode table
      for (int i = 0; i < 13; i++) begin
         drive(vecs[i].instr, vecs[i].validd, 1'b0, 1'b0);
         PCD = 32'h1000 + 32'(4 * i); PCPlus4D = PCD + 32'd4;
         tick("tbl");
         check("tbl_ctrl", {180'd0, act_ctrl()}, {180'd0, vecs[i].ctrl});
         check("tbl_imm", {160'd0, Imm_Ext_E}, {160'd0, vecs[i].imm});
      end

      // Write-through, then x0 write ignored, then normal read of x1
      drive(32'h000081B3, 1'b1, 1'b0, 1'b0);
      RegWriteW = 1'b1; RDW = 5'd1; ResultW = 32'h12345678;
      tick("wt");
      check("wt_rd1", {160'd0, RD1_E}, {160'd0, 32'h12345678});
      check("wt_rd2", {160'd0, RD2_E}, 192'd0);
      drive(32'h000001B3, 1'b1, 1'b0, 1'b0);
      RDW = 5'd0; ResultW = 32'hDEADBEEF;
      tick("x0w");
      check("x0_bypass", {160'd0, RD1_E}, 192'd0);
      RegWriteW = 1'b0;
      tick("x0r");
      check("x0_read", {160'd0, RD1_E}, 192'd0);
      drive(32'h000081B3, 1'b1, 1'b0, 1'b0);
      tick("x1r");
      check("x1_read", {160'd0, RD1_E}, {160'd0, 32'h12345678});

      // Stall for two cycles while InstrD changes, then flush during stall
      drive(32'h00F00793, 1'b1, 1'b0, 1'b0);
      tick("pre_stall");
      drive(32'hFE000CE3, 1'b1, 1'b1, 1'b0);
      tick("stall1");
      drive(32'hFFFFFFFF, 1'b1, 1'b1, 1'b0);
      tick("stall2");
      check("stall_ctrl", {180'd0, act_ctrl()}, {180'd0, 12'hE00});
      check("stall_imm", {160'd0, Imm_Ext_E}, {160'd0, 32'h0000000F});
      drive(32'h00F00793, 1'b1, 1'b1, 1'b1);
      tick("flush");
      check("flush_ctrl", {180'd0, act_ctrl()}, 192'd0);

`ifdef LOAD_USE_HAZARD_EN
      drive(32'h0000A283, 1'b1, 1'b0, 1'b0);
      tick("lw");
      drive(32'h00028333, 1'b1, 1'b0, 1'b0);
      check("lu_assert", {191'd0, LoadUseStallD}, 192'd1);
      tick("lu_bubble");
      check("lu_bubble_valid", {191'd0, ValidE}, 192'd0);
      check("lu_release", {191'd0, LoadUseStallD}, 192'd0);
      tick("lu_add");
      check("lu_add_valid", {191'd0, ValidE}, 192'd1);
      check("lu_add_rs1", {187'd0, RS1_E}, 192'd5);
`endif

      // Randomized traffic against the model
      for (int n = 0; n < 400; n++) begin
         drive(rand_instr(), ($urandom_range(0, 99) < 85), ($urandom_range(0, 99) < 15),
               ($urandom_range(0, 99) < 8));
         PCD = $urandom(); PCPlus4D = PCD + 32'd4;
         RegWriteW = ($urandom_range(0, 99) < 60);
         RDW = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
         ResultW = $urandom();
         tick("rand");
      end

      // Asynchronous reset between edges
      RegWriteW = 1'b0;
      drive(32'h00F00793, 1'b1, 1'b0, 1'b0);
      tick("pre_arst");
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check("arst_ctrl", {180'd0, act_ctrl()}, 192'd0);
      check("arst_data", {17'd0, act_data()}, 192'd0);
      @(negedge clk);
      rst = 1'b0;
      drive(32'h000081B3, 1'b1, 1'b0, 1'b0);
      tick("post_arst");
      check("arst_rf", {160'd0, RD1_E}, 192'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/decode_stage_pl.md
Name: decode_stage_pl

Overview:
Parametrised successor to the single-issue decode cycle for the RISC-V pipelined core. Contains the architectural register file with write-through bypass, the RV32I-subset main/ALU decoder, the immediate generator and the ID/EX pipeline register. Adds stall, flush, valid and illegal-instruction tracking, plus optional load-use hazard detection. Sits between fetch (IF/ID register) and execute.

Parameters:
XLEN, 32, data/PC width
NUM_REGS, 32, register file entries; power of two, at least 2; x0 hardwired to zero
RA_W, $clog2(NUM_REGS), register address width (derived, not overridden)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
ValidD  in  1  IF/ID slot holds a real instruction
InstrD  in  32  instruction word
PCD  in  XLEN  PC of InstrD
PCPlus4D  in  XLEN  PC+4 of InstrD
StallD  in  1  hold ID/EX register
FlushE  in  1  load a bubble into ID/EX
RegWriteW  in  1  writeback enable
RDW  in  RA_W  writeback destination
ResultW  in  XLEN  writeback data
ValidE, RegWriteE, ALUSrcE, MemWriteE, BranchE, JumpE, IllegalE  out  1 each  registered control
ResultSrcE  out  2  00 ALU, 01 memory, 10 PC+4
ALUControlE  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E  out  XLEN  registered data
RS1_E, RS2_E, RD_E  out  RA_W  registered register indices (low RA_W bits of the instruction fields)

Behaviour:
- Reset (asynchronous): every ID/EX output is 0; all register file entries are 0.
- Register file write: on a rising edge, when RegWriteW=1 and RDW!=0. A write to x0 is ignored. Writes occur regardless of StallD/FlushE.
- Register file read: combinational. Write-through: if RegWriteW=1, RDW==rs and rs!=0, the read returns ResultW. A read of x0 always returns 0.
- Decoder, per opcode:
  - 0000011 lw: RegWrite, ALUSrc, ResultSrc=01, I-imm.
  - 0100011 sw: MemWrite, ALUSrc, S-imm.
  - 0110011 R-type: RegWrite. funct3/funct7[5] select add/sub/and/or/slt.
  - 0010011 I-ALU: RegWrite, ALUSrc, I-imm. funct7 is ignored, so no subi.
  - 1100011 beq: Branch, ALUControl=sub, B-imm.
  - 1101111 jal: RegWrite, Jump, ResultSrc=10, J-imm.
  - Any other opcode or funct combination: all controls 0 and Illegal=1.
- Immediates: sign-extended to XLEN. The B and J immediates have bit 0 = 0.
- ID/EX update priority on each edge: FlushE > StallD > ValidD.
  - FlushE: all control bits, ValidE and IllegalE go to 0. Data fields go to 0.
  - StallD: all outputs hold their values.
  - ValidD=0: loaded as a bubble, same as flush.
  - Otherwise: the decoded values load.
- Latency: InstrD to E outputs is 1 cycle. RD1_E/RD2_E capture the values as they stand at the edge.
- While stalled, a held RD1_E/RD2_E may become stale after a writeback. Correcting this is the forwarding unit's job and is out of scope here.
- rst asserted mid-operation clears the state immediately, independent of clk.

Optional Feature:
Macro LOAD_USE_HAZARD_EN.
- Defined:
  - Adds output LoadUseStallD (1 bit, combinational).
  - LoadUseStallD = ValidE & ResultSrcE==01 & RD_E!=0 & (RD_E==rs1 or RD_E==rs2 of InstrD) & ValidD.
  - When it is asserted and FlushE=0, ID/EX loads a bubble. Fetch must hold IF/ID while LoadUseStallD=1.
  - External StallD still overrides it, i.e. ID/EX holds.
- Undefined: the port is absent and there is no internal hazard logic.

Test Plan:
- Reset, then InstrD=00F00793 (addi x15,x0,15), ValidD=1 -> after 1 edge: RegWriteE=1, ALUSrcE=1, ALUControlE=000, Imm_Ext_E=0000000F, RD_E=15, RS1_E=0, ValidE=1.
- RegWriteW=1, RDW=1, ResultW=12345678 on the same cycle as InstrD=000081B3 (add x3,x1,x0) -> RD1_E=12345678 (write-through), RD2_E=0. A later write of DEADBEEF to RDW=0 leaves x0 reading 0.
- InstrD=FE000CE3 (beq x0,x0,-8) -> BranchE=1, ALUControlE=001, Imm_Ext_E=FFFFFFF8, RegWriteE=0.
- Load any instruction, assert StallD for 2 cycles while InstrD changes -> E outputs unchanged. FlushE=1 together with StallD=1 -> all controls and ValidE=0. InstrD=FFFFFFFF -> IllegalE=1 and all other controls 0.
- LOAD_USE_HAZARD_EN defined: lw x5,0(x1) (0000A283), then add x6,x5,x0 (00028333) -> LoadUseStallD=1 for one cycle, a bubble (ValidE=0) in EX, then the add enters EX with RS1_E=5.
- Assert rst asynchronously between clock edges with ValidE=1 -> all outputs become 0 before the next edge.
